// File: rtl/switch_allocator_if.sv
// Allocator-side bundle between the input ports and the crossbar.
// The input-port side drives requests; the allocator returns grants and crossbar selects.
interface switch_allocator_if #(
  parameter int PORT_NUM  = 5,
  parameter int VC_NUM    = 2,
  parameter int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  parameter int PORT_SIZE = $clog2(PORT_NUM)
);
  logic [PORT_NUM-1:0][VC_NUM-1:0]                request_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] out_port_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]   ds_vc_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0]                on_off_i;
  logic [PORT_NUM-1:0]                            valid_sel_o;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]               vc_sel_o;
  logic [PORT_NUM-1:0]                            xb_valid_o;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0]             xb_sel_o;

  modport master (
    output request_i, out_port_i, ds_vc_i, on_off_i,
    input  valid_sel_o, vc_sel_o, xb_valid_o, xb_sel_o
  );

  modport slave (
    input  request_i, out_port_i, ds_vc_i, on_off_i,
    output valid_sel_o, vc_sel_o, xb_valid_o, xb_sel_o
  );
endinterface

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator: per-input round-robin VC pick, then
// per-output round-robin input pick; grants and pointers are registered.
module switch_allocator #(
  parameter int PORT_NUM  = 5,
  parameter int VC_NUM    = 2,
  parameter int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  parameter int PORT_SIZE = $clog2(PORT_NUM)
) (
  input  logic               clk,
  input  logic               rst,
  switch_allocator_if.slave  bus
);

  logic [PORT_NUM-1:0]                 r_valid_sel;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]    r_vc_sel;
  logic [PORT_NUM-1:0]                 r_xb_valid;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0]  r_xb_sel;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]    r_in_ptr;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0]  r_out_ptr;

  logic [PORT_NUM-1:0][VC_NUM-1:0]     w_elig;
  logic [PORT_NUM-1:0]                 w_cand_valid;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]    w_cand_vc;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0]  w_cand_out;
  logic [PORT_NUM-1:0]                 w_in_grant;
  logic [PORT_NUM-1:0]                 w_out_grant;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0]  w_out_src;

  function automatic logic [VC_SIZE-1:0] next_vc(input logic [VC_SIZE-1:0] v);
    return VC_SIZE'((int'(v) + 1) % VC_NUM);
  endfunction

  function automatic logic [PORT_SIZE-1:0] next_port(input logic [PORT_SIZE-1:0] p);
    return PORT_SIZE'((int'(p) + 1) % PORT_NUM);
  endfunction

  // A VC is eligible only if its downstream VC currently reports space.
  always_comb begin : eligibility
    // NOTE: every combinationally assigned signal gets a default first so no path can infer a latch.
    w_elig = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (int'(bus.out_port_i[p][v]) < PORT_NUM)
          w_elig[p][v] = bus.request_i[p][v]
                       & bus.on_off_i[bus.out_port_i[p][v]][bus.ds_vc_i[p][v]];
      end
    end
  end

  always_comb begin : stage1
    int v;
    v            = 0;
    w_cand_valid = '0;
    w_cand_vc    = '0;
    w_cand_out   = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int k = 0; k < VC_NUM; k++) begin
        v = (int'(r_in_ptr[p]) + k) % VC_NUM;
        if (!w_cand_valid[p] && w_elig[p][v]) begin
          w_cand_valid[p] = 1'b1;
          w_cand_vc[p]    = VC_SIZE'(v);
          w_cand_out[p]   = bus.out_port_i[p][v];
        end
      end
    end
  end

  // A stage-1 candidate that loses here gets no retry this cycle.
  always_comb begin : stage2
    int p;
    p           = 0;
    w_in_grant  = '0;
    w_out_grant = '0;
    w_out_src   = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int k = 0; k < PORT_NUM; k++) begin
        p = (int'(r_out_ptr[o]) + k) % PORT_NUM;
        if (!w_out_grant[o] && w_cand_valid[p] && int'(w_cand_out[p]) == o) begin
          w_out_grant[o] = 1'b1;
          w_out_src[o]   = PORT_SIZE'(p);
          w_in_grant[p]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_valid_sel <= '0;
      r_vc_sel    <= '0;
      r_xb_valid  <= '0;
      r_xb_sel    <= '0;
      r_in_ptr    <= '0;
      r_out_ptr   <= '0;
    end else begin
      r_valid_sel <= w_in_grant;
      r_xb_valid  <= w_out_grant;
      for (int p = 0; p < PORT_NUM; p++) begin
        if (w_in_grant[p]) begin
          r_vc_sel[p] <= w_cand_vc[p];
          r_in_ptr[p] <= next_vc(w_cand_vc[p]);
        end
      end
      for (int o = 0; o < PORT_NUM; o++) begin
        if (w_out_grant[o]) begin
          r_xb_sel[o]  <= w_out_src[o];
          r_out_ptr[o] <= next_port(w_out_src[o]);
        end
      end
    end
  end

  assign bus.valid_sel_o = r_valid_sel;
  assign bus.vc_sel_o    = r_vc_sel;
  assign bus.xb_valid_o  = r_xb_valid;
  assign bus.xb_sel_o    = r_xb_sel;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed and randomized checks of switch_allocator against a behavioural
// two-stage round-robin model.
module tb_switch_allocator;
  localparam int PORT_NUM  = 5;
  localparam int VC_NUM    = 2;
  localparam int VC_SIZE   = 1;
  localparam int PORT_SIZE = 3;
  localparam int LOCAL = 0, NORTH = 1, SOUTH = 2, WEST = 3, EAST = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;

  switch_allocator_if u_if ();
  switch_allocator u_dut (.clk(clk), .rst(rst), .bus(u_if.slave));

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_total=%0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  // Reference model state.
  int m_in_ptr  [PORT_NUM];
  int m_out_ptr [PORT_NUM];
  logic [PORT_NUM-1:0]                m_valid_sel;
  logic [PORT_NUM-1:0][VC_SIZE-1:0]   m_vc_sel;
  logic [PORT_NUM-1:0]                m_xb_valid;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] m_xb_sel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit eligible(input int p, input int v);
    int o, d;
    o = int'(u_if.out_port_i[p][v]);
    d = int'(u_if.ds_vc_i[p][v]);
    return u_if.request_i[p][v] && u_if.on_off_i[o][d];
  endfunction

  task automatic model_step();
    int cand [PORT_NUM];
    int p, v;
    m_valid_sel = '0;
    m_xb_valid  = '0;
    if (rst) begin
      m_vc_sel = '0;
      m_xb_sel = '0;
      for (int i = 0; i < PORT_NUM; i++) begin
        m_in_ptr[i]  = 0;
        m_out_ptr[i] = 0;
      end
      return;
    end
    for (int i = 0; i < PORT_NUM; i++) begin
      cand[i] = -1;
      for (int k = 0; k < VC_NUM; k++) begin
        v = (m_in_ptr[i] + k) % VC_NUM;
        if (cand[i] < 0 && eligible(i, v)) cand[i] = v;
      end
    end
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int k = 0; k < PORT_NUM; k++) begin
        p = (m_out_ptr[o] + k) % PORT_NUM;
        if (!m_xb_valid[o] && cand[p] >= 0 && int'(u_if.out_port_i[p][cand[p]]) == o) begin
          m_xb_valid[o]  = 1'b1;
          m_xb_sel[o]    = PORT_SIZE'(p);
          m_valid_sel[p] = 1'b1;
          m_vc_sel[p]    = VC_SIZE'(cand[p]);
          m_in_ptr[p]    = (cand[p] + 1) % VC_NUM;
          m_out_ptr[o]   = (p + 1) % PORT_NUM;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("model_valid_sel", 32'(u_if.valid_sel_o), 32'(m_valid_sel));
    check("model_vc_sel",    32'(u_if.vc_sel_o),    32'(m_vc_sel));
    check("model_xb_valid",  32'(u_if.xb_valid_o),  32'(m_xb_valid));
    check("model_xb_sel",    32'(u_if.xb_sel_o),    32'(m_xb_sel));
  endtask

  task automatic clear_inputs();
    u_if.request_i  = '0;
    u_if.out_port_i = '0;
    u_if.ds_vc_i    = '0;
    u_if.on_off_i   = '1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int exp_seq [6];
    exp_seq = '{0, 1, 3, 0, 1, 3};

    // Reset held with everything requesting.
    rst = 1'b1;
    clear_inputs();
    u_if.request_i = '1;
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_NUM; v++)
        u_if.out_port_i[p][v] = PORT_SIZE'((p + v) % PORT_NUM);
    repeat (3) begin
      cycle();
      check("rst_valid_sel", 32'(u_if.valid_sel_o), 32'(0));
      check("rst_xb_valid",  32'(u_if.xb_valid_o),  32'(0));
      check("rst_vc_sel",    32'(u_if.vc_sel_o),    32'(0));
      check("rst_xb_sel",    32'(u_if.xb_sel_o),    32'(0));
    end
    rst = 1'b0;
    cycle();
    check("rst_release_grant", 32'(|u_if.valid_sel_o), 32'(1));

    // Reset asserted mid-operation drops grants on the next edge.
    rst = 1'b1;
    cycle();
    check("mid_rst_valid", 32'(u_if.valid_sel_o), 32'(0));
    rst = 1'b0;

    // Single request (2,1) -> EAST, for exactly one cycle.
    do_reset();
    clear_inputs();
    u_if.request_i[2][1]  = 1'b1;
    u_if.out_port_i[2][1] = PORT_SIZE'(EAST);
    cycle();
    check("single_valid_sel", 32'(u_if.valid_sel_o),    32'(5'b00100));
    check("single_vc_sel",    32'(u_if.vc_sel_o[2]),    32'(1));
    check("single_xb_valid",  32'(u_if.xb_valid_o),     32'(5'b10000));
    check("single_xb_sel",    32'(u_if.xb_sel_o[EAST]), 32'(2));
    u_if.request_i = '0;
    cycle();
    check("single_drop_valid", 32'(u_if.valid_sel_o),   32'(0));
    check("single_drop_xb",    32'(u_if.xb_valid_o),    32'(0));
    check("single_hold_vc",    32'(u_if.vc_sel_o[2]),   32'(1));

    // Output contention on LOCAL from inputs 0, 1, 3.
    do_reset();
    clear_inputs();
    u_if.request_i[0][0] = 1'b1;
    u_if.request_i[1][0] = 1'b1;
    u_if.request_i[3][0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("contend_xb_sel",    32'(u_if.xb_sel_o[LOCAL]), 32'(exp_seq[i]));
      check("contend_xb_valid",  32'(u_if.xb_valid_o),      32'(5'b00001));
      check("contend_valid_sel", 32'(u_if.valid_sel_o),     32'(1) << exp_seq[i]);
    end

    // VC rotation at input 1: VC0 -> NORTH, VC1 -> SOUTH.
    do_reset();
    clear_inputs();
    u_if.request_i[1]     = 2'b11;
    u_if.out_port_i[1][0] = PORT_SIZE'(NORTH);
    u_if.out_port_i[1][1] = PORT_SIZE'(SOUTH);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("vcrot_vc_sel",   32'(u_if.vc_sel_o[1]), 32'(i % 2));
      check("vcrot_xb_valid", 32'(u_if.xb_valid_o),  (i % 2 == 1) ? 32'(5'b00100) : 32'(5'b00010));
    end

    // Backpressure on WEST downstream VC1.
    do_reset();
    clear_inputs();
    u_if.request_i[4][0]  = 1'b1;
    u_if.out_port_i[4][0] = PORT_SIZE'(WEST);
    u_if.ds_vc_i[4][0]    = 1'b1;
    u_if.on_off_i[WEST][1] = 1'b0;
    repeat (4) begin
      cycle();
      check("bp_blocked", 32'(u_if.valid_sel_o), 32'(0));
    end
    u_if.on_off_i[WEST][1] = 1'b1;
    cycle();
    check("bp_release_valid", 32'(u_if.valid_sel_o),    32'(5'b10000));
    check("bp_release_xb",    32'(u_if.xb_sel_o[WEST]), 32'(4));

    // Stage-2 loser keeps its VC pointer.
    do_reset();
    clear_inputs();
    u_if.request_i[0][0]  = 1'b1;
    u_if.out_port_i[0][0] = PORT_SIZE'(EAST);
    u_if.request_i[2]     = 2'b11;
    u_if.out_port_i[2][0] = PORT_SIZE'(EAST);
    u_if.out_port_i[2][1] = PORT_SIZE'(NORTH);
    cycle();
    check("loser_c1_valid", 32'(u_if.valid_sel_o),    32'(5'b00001));
    check("loser_c1_xb",    32'(u_if.xb_valid_o),     32'(5'b10000));
    cycle();
    check("loser_c2_valid", 32'(u_if.valid_sel_o),    32'(5'b00100));
    check("loser_c2_vc",    32'(u_if.vc_sel_o[2]),    32'(0));
    check("loser_c2_xb",    32'(u_if.xb_sel_o[EAST]), 32'(2));

    // Randomized traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int p = 0; p < PORT_NUM; p++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          u_if.request_i[p][v]  = ($urandom_range(0, 9) < 7);
          u_if.out_port_i[p][v] = PORT_SIZE'($urandom_range(0, PORT_NUM - 1));
          u_if.ds_vc_i[p][v]    = VC_SIZE'($urandom_range(0, VC_NUM - 1));
          u_if.on_off_i[p][v]   = ($urandom_range(0, 3) != 0);
        end
      end
      cycle();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/switch_allocator.md
# switch_allocator

Separable input-first switch allocator for the mesh router, sitting directly downstream of the per-port `input_port` instances. Each cycle it chooses at most one VC per input port and at most one input port per output port, honouring downstream on/off backpressure. It drives each input port's `vc_sel_i`/`valid_sel_i` and the crossbar input-select lines. Round-robin fairness is kept at both arbitration stages.

## Interface
Parameters (`PORT_NUM`, `VC_NUM`, `VC_SIZE`, `PORT_SIZE` and `port_t` come from `noc_params`):
- `PORT_NUM`, 5, number of router ports (LOCAL, NORTH, SOUTH, WEST, EAST), indexed by `port_t` value.
- `VC_NUM`, 2, VCs per port.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `request_i`  in  [PORT_NUM][VC_NUM]  VC is VA-done and its buffer is non-empty.
- `out_port_i`  in  port_t [PORT_NUM][VC_NUM]  output port of each VC's current packet.
- `ds_vc_i`  in  [PORT_NUM][VC_NUM][VC_SIZE]  downstream VC assigned by VA.
- `on_off_i`  in  [PORT_NUM][VC_NUM]  downstream on/off per output port and downstream VC; 1 means space is available.
- `valid_sel_o`  out  [PORT_NUM]  input port p is granted this cycle.
- `vc_sel_o`  out  [PORT_NUM][VC_SIZE]  granted VC of input port p.
- `xb_valid_o`  out  [PORT_NUM]  output port o is driven this cycle.
- `xb_sel_o`  out  [PORT_NUM][PORT_SIZE]  input port connected to output o.

## Operation
- **Eligibility.** VC (p,v) is eligible when `request_i[p][v]` is 1 and `on_off_i[out_port_i[p][v]][ds_vc_i[p][v]]` is 1.
- **Stage 1 (per input p).** A round-robin arbiter picks one eligible VC.
  - Priority starts at `in_ptr[p]` and wraps modulo VC_NUM.
  - The result is candidate `c[p]`, targeting output `out_port_i[p][c[p]]`.
- **Stage 2 (per output o).** A round-robin arbiter picks one input among those whose candidate targets o.
  - Priority starts at `out_ptr[o]` and wraps modulo PORT_NUM.
- **Pointer update.** Pointers change only on a final grant.
  - A losing stage-1 candidate does not move `in_ptr`.
  - On a grant of input p / VC v to output o: `in_ptr[p] <= (v+1) mod VC_NUM` and `out_ptr[o] <= (p+1) mod PORT_NUM`.
- **Grant properties.**
  - At most one grant per input and per output.
  - An input with an eligible VC is not granted if it loses stage 2.
  - No second-chance iteration is performed.
- **U-turns.** A request whose `out_port_i` equals its own input port index is still arbitrated normally. The routing logic never produces one.
- **Output mapping.** For each granted pair (p,v,o):
  - `valid_sel_o[p]=1`, `vc_sel_o[p]=v`.
  - `xb_valid_o[o]=1`, `xb_sel_o[o]=p`.
- **Ungranted lines.** Valid bits are 0. `vc_sel_o`/`xb_sel_o` hold their previous value, and consumers ignore them when valid is 0.
- **Implementation.** Both stages are combinational from registered pointers. Outputs and pointers are registered.

## Timing
- **Reset.** Synchronous and active-high.
  - Clears `valid_sel_o`, `xb_valid_o`, `vc_sel_o` and `xb_sel_o` to 0.
  - Clears `in_ptr` and `out_ptr` to 0.
  - While `rst` is 1, no grant is issued, regardless of inputs.
  - Reset asserted mid-operation drops any grant on the next edge.
- **Latency.** Inputs sampled at edge t produce grants visible after edge t+1 and valid for exactly one cycle. The input port pops its flit on edge t+1's consumer edge (the same `valid_sel_i` timing `input_port` uses).
- **Back-to-back grants.** A VC may be granted on consecutive cycles while `request_i` and `on_off_i` stay 1. Throughput is 1 flit/cycle per output.
- **Backpressure.** `on_off_i` is sampled in the same cycle as the request. If `on_off_i` drops at edge t, no grant for that downstream VC appears after edge t+1.
- **Simultaneous events.**
  - If a request drops in the same cycle as arbitration, the stale grant must not occur: requests are sampled, never latched.
  - Two inputs tie on one output: the lower index wins, counted cyclically from `out_ptr`.
- **Wrap-around.** `in_ptr` at VC_NUM-1 advances to 0. `out_ptr` at PORT_NUM-1 advances to 0.

## Test plan
- **Reset.** Hold `rst`=1 for 3 cycles with all `request_i`=1 and all `on_off_i`=1 → all outputs stay 0. After release, the first grants appear exactly 1 cycle later.
- **Single request.** Only (p=2,v=1) requests, targeting o=EAST with `on_off_i`=1 → for exactly one cycle:
  - `valid_sel_o[2]=1`, `vc_sel_o[2]=1`.
  - `xb_valid_o[EAST]=1`, `xb_sel_o[EAST]=2`.
- **Output contention.** Inputs 0, 1 and 3 continuously request output LOCAL on VC0 → grants rotate 0, 1, 3, 0, 1, 3, … with exactly one grant per cycle.
- **Input VC rotation.** Input 1 has both VCs requesting, to NORTH and to SOUTH → VC grants alternate 0, 1, 0, 1. `xb_valid_o[NORTH]` and `xb_valid_o[SOUTH]` alternate.
- **Backpressure.** Input 4 VC0 requests WEST with `ds_vc`=1.
  - Drive `on_off_i[WEST][1]=0` for 4 cycles → no grant during those cycles.
  - Restore it to 1 → a grant appears 1 cycle later.
- **Stage-2 loser.** Inputs 0 and 2 both target EAST, and input 2 also has a VC1 request to NORTH.
  - Input 2's stage-1 pick (VC0) loses to input 0 → `in_ptr[2]` is unchanged, and input 2 VC0 wins the next cycle.
